// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single DMem port.
// Ports: clk, rst_n; per requester (a_*, b_*) req/we/addr/wdata in and
// ack/rdata/err out; mem_ewr/mem_erd/mem_addr/mem_wdata out, mem_rdata in;
// busy (state != IDLE) and owner (port of current/last grant, 0=A 1=B).
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          mem_ewr,
  output logic          mem_erd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [AW-1:0] LP_DEPTH = AW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_owner;
  logic          r_port;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic          r_a_err;
  logic          r_b_err;

  logic          w_any;
  logic          w_gnt_b;
  logic          w_in_range;

  assign w_any = a_req | b_req;

  // B wins when alone, or on a tie when A owned the last grant.
  assign w_gnt_b = b_req & (~a_req | ~r_owner);

  assign w_in_range = (r_addr < LP_DEPTH);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // DMem strobes are decoded from the state register only, so
  // an async reset in ACCESS kills mem_ewr at once.
  always_comb begin
    mem_ewr   = 1'b0;
    mem_erd   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == S_ACCESS && w_in_range) begin
      mem_addr = r_addr;
      mem_ewr  = r_we;
      mem_erd  = ~r_we;
      if (r_we) begin
        mem_wdata = r_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_port  <= w_gnt_b;
            r_owner <= w_gnt_b;
            r_we    <= w_gnt_b ? b_we    : a_we;
            r_addr  <= w_gnt_b ? b_addr  : a_addr;
            r_wdata <= w_gnt_b ? b_wdata : a_wdata;
          end
        end
        S_ACCESS: begin
          if (!w_in_range) begin
            if (r_port) begin
              r_b_err <= 1'b1;
            end else begin
              r_a_err <= 1'b1;
            end
          end else if (!r_we) begin
            if (r_port) begin
              r_b_rdata <= mem_rdata;
            end else begin
              r_a_rdata <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          r_a_rdata <= '0;
          r_b_rdata <= '0;
          r_a_err   <= 1'b0;
          r_b_err   <= 1'b0;
        end
        default: begin
          r_a_err   <= 1'b0;
          r_b_err   <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack   = (r_state == S_RESP) & ~r_port;
  assign b_ack   = (r_state == S_RESP) &  r_port;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign a_err   = r_a_err;
  assign b_err   = r_b_err;
  assign busy    = (r_state != S_IDLE);
  assign owner   = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-word DMem model.
// Outputs sampled 1 time unit after each rising edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0;
  logic        a_we = 1'b0;
  logic [31:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        a_err;
  logic        b_req = 1'b0;
  logic        b_we = 1'b0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_err;
  logic        mem_ewr;
  logic        mem_erd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  logic [31:0] mem [32] = '{default: '0};
  int          wr_cnt = 0;
  int          bad_wr = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(32), .AW(32), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_ewr(mem_ewr), .mem_erd(mem_erd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always_comb begin
    mem_rdata = '0;
    if (mem_addr < 32) mem_rdata = mem[mem_addr[4:0]];
  end

  always @(posedge clk) begin
    if (mem_ewr) begin
      wr_cnt++;
      if (mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
      else bad_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_a;
    logic exp_b;

    // reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_ack", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst_mem", {30'd0, mem_ewr, mem_erd}, 32'd0);
    chk("rst_rdata", a_rdata | b_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: A write 5 = DEADBEEF
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'hDEADBEEF;
    tick();
    a_wdata = 32'h0; a_addr = 32'd6;
    chk("s1_ewr", 32'(mem_ewr), 32'd1);
    chk("s1_erd", 32'(mem_erd), 32'd0);
    chk("s1_addr", mem_addr, 32'd5);
    chk("s1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s1_owner", 32'(owner), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    tick();
    chk("s1_ewr_off", 32'(mem_ewr), 32'd0);
    chk("s1_ack", 32'(a_ack), 32'd1);
    chk("s1_err", 32'(a_err), 32'd0);
    chk("s1_rdata", a_rdata, 32'd0);
    chk("s1_back", 32'(b_ack), 32'd0);
    tick();
    a_req = 1'b0;
    chk("s1_ack_end", 32'(a_ack), 32'd0);
    chk("s1_idle", 32'(busy), 32'd0);
    chk("s1_mem5", mem[5], 32'hDEADBEEF);
    chk("s1_wrcnt", 32'(wr_cnt), 32'd1);

    // 2: A read 5
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
    tick();
    chk("s2_erd", 32'(mem_erd), 32'd1);
    chk("s2_ewr", 32'(mem_ewr), 32'd0);
    chk("s2_addr", mem_addr, 32'd5);
    tick();
    chk("s2_ack", 32'(a_ack), 32'd1);
    chk("s2_rdata", a_rdata, 32'hDEADBEEF);
    chk("s2_back", 32'(b_ack), 32'd0);
    chk("s2_erd_off", 32'(mem_erd), 32'd0);
    tick();
    a_req = 1'b0;
    chk("s2_rdata_clr", a_rdata, 32'd0);

    // 3: simultaneous after reset, A read 5 / B write 7
    rst_n = 1'b0;
    #1;
    chk("s3_rst_owner", 32'(owner), 32'd1);
    tick();
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'h12345678;
    tick();
    chk("s3_owner_a", 32'(owner), 32'd0);
    chk("s3_a_addr", mem_addr, 32'd5);
    chk("s3_a_erd", 32'(mem_erd), 32'd1);
    tick();
    chk("s3_a_ack", 32'(a_ack), 32'd1);
    chk("s3_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("s3_b_wait", 32'(b_ack), 32'd0);
    tick();
    a_req = 1'b0;
    tick();
    chk("s3_owner_b", 32'(owner), 32'd1);
    chk("s3_b_ewr", 32'(mem_ewr), 32'd1);
    chk("s3_b_addr", mem_addr, 32'd7);
    tick();
    chk("s3_b_ack", 32'(b_ack), 32'd1);
    chk("s3_b_err", 32'(b_err), 32'd0);
    chk("s3_a_quiet", 32'(a_ack), 32'd0);
    tick();
    b_req = 1'b0;
    chk("s3_mem7", mem[7], 32'h12345678);

    // 4: both hold req for 12 cycles, reads of 5 and 7
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd7;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_a = (i % 3 == 1) && ((i / 3) % 2 == 0);
      exp_b = (i % 3 == 1) && ((i / 3) % 2 == 1);
      chk($sformatf("s4_a_ack_%0d", i), 32'(a_ack), 32'(exp_a));
      chk($sformatf("s4_b_ack_%0d", i), 32'(b_ack), 32'(exp_b));
      if (exp_a) chk($sformatf("s4_a_rd_%0d", i), a_rdata, 32'hDEADBEEF);
      if (exp_b) chk($sformatf("s4_b_rd_%0d", i), b_rdata, 32'h12345678);
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("s4_owner", 32'(owner), 32'd1);
    chk("s4_busy", 32'(busy), 32'd0);

    // 5: B write out of range
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd40; b_wdata = 32'h55555555;
    tick();
    chk("s5_ewr", 32'(mem_ewr), 32'd0);
    chk("s5_erd", 32'(mem_erd), 32'd0);
    chk("s5_owner", 32'(owner), 32'd1);
    tick();
    chk("s5_ack", 32'(b_ack), 32'd1);
    chk("s5_err", 32'(b_err), 32'd1);
    chk("s5_rdata", b_rdata, 32'd0);
    chk("s5_a_ack", 32'(a_ack), 32'd0);
    tick();
    b_req = 1'b0;
    chk("s5_err_clr", 32'(b_err), 32'd0);
    chk("s5_wrcnt", 32'(wr_cnt), 32'd2);
    chk("s5_badwr", 32'(bad_wr), 32'd0);

    // 6: reset during ACCESS of A write
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd9; a_wdata = 32'hAAAA5555;
    tick();
    chk("s6_ewr_on", 32'(mem_ewr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    a_req = 1'b0;
    chk("s6_ewr_drop", 32'(mem_ewr), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_owner", 32'(owner), 32'd1);
    chk("s6_ack", 32'(a_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s6_noack", 32'(a_ack), 32'd0);
    chk("s6_mem9", mem[9], 32'd0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'h0BADF00D;
    tick();
    chk("s6_re_ewr", 32'(mem_ewr), 32'd1);
    chk("s6_re_addr", mem_addr, 32'd3);
    tick();
    chk("s6_re_ack", 32'(a_ack), 32'd1);
    tick();
    a_req = 1'b0;
    chk("s6_mem3", mem[3], 32'h0BADF00D);
    chk("s6_wrcnt", 32'(wr_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
